rvfpm_issue_queue: RTL and testbench

Instruction issue buffer directly upstream of the rvfpm FPU core. Accepts offloaded floating-point instructions (instruction word, CORE-V-XIF id, integer-register operand) from the core through a valid/ready handshake and holds them in a QUEUE_DEPTH-entry FIFO. Presents the oldest entry to the FPU on its enable/instruction/id/data_fromXReg inputs, and pops it when the FPU signals fpu_ready. Decouples core issue rate from FPU pipeline stalls.

---
 rtl/rvfpm_issue_queue.sv | 105 ++++++++++
 tb/tb_rvfpm_issue_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rvfpm_issue_queue.sv
// rvfpm_issue_queue: in-order instruction buffer in front of the rvfpm FPU.
// Holds offloaded instructions and presents the oldest one to the FPU.
module rvfpm_issue_queue #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned XLEN        = 32
) (
  input  logic                             ck,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_instruction,
  input  logic [X_ID_WIDTH-1:0]            in_id,
  input  logic [XLEN-1:0]                  in_xreg_data,
  input  logic                             flush,
  input  logic                             fpu_ready,
  output logic                             enable,
  output logic [31:0]                      instruction,
  output logic [X_ID_WIDTH-1:0]            id,
  output logic [XLEN-1:0]                  data_fromXReg,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PW =
    (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef struct packed {
    logic [31:0]           instr;
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       xreg;
  } entry_t;

  entry_t          mem_q [QUEUE_DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_s, empty_s;
  logic            push, pop;

  // Modulo increment so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_s   = (count_q == CW'(QUEUE_DEPTH));
  assign empty_s  = (count_q == '0);
  assign in_ready = !full_s && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !empty_s && fpu_ready;

  assign in_entry = '{instr: in_instruction,
                      id:    in_id,
                      xreg:  in_xreg_data};

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wrap_inc(wptr_q);
      if (pop)  rptr_d = wrap_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge ck) begin
    if (push) mem_q[wptr_q] <= in_entry;
  end

  assign head          = mem_q[rptr_q];
  assign enable        = !empty_s;
  assign instruction   = empty_s ? '0 : head.instr;
  assign id            = empty_s ? '0 : head.id;
  assign data_fromXReg = empty_s ? '0 : head.xreg;
  assign count         = count_q;
  assign full          = full_s;
  assign empty         = empty_s;

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// tb_rvfpm_issue_queue: directed and random checks of rvfpm_issue_queue
// against a queue-based reference model.
module tb_rvfpm_issue_queue;

  localparam int XW  = 4;
  localparam int DEP = 4;
  localparam int XL  = 32;
  localparam int CW  = $clog2(DEP + 1);

  typedef struct {
    logic [31:0]   instr;
    logic [XW-1:0] id;
    logic [XL-1:0] xreg;
  } ent_t;

  logic          ck = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instruction;
  logic [XW-1:0] in_id;
  logic [XL-1:0] in_xreg_data;
  logic          flush;
  logic          fpu_ready;
  logic          enable;
  logic [31:0]   instruction;
  logic [XW-1:0] id;
  logic [XL-1:0] data_fromXReg;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int nvec = 0;
  int nerr = 0;
  ent_t mq[$];

  rvfpm_issue_queue #(
    .X_ID_WIDTH(XW), .QUEUE_DEPTH(DEP), .XLEN(XL)
  ) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_id(in_id),
    .in_xreg_data(in_xreg_data),
    .flush(flush), .fpu_ready(fpu_ready),
    .enable(enable), .instruction(instruction), .id(id),
    .data_fromXReg(data_fromXReg),
    .count(count), .full(full), .empty(empty)
  );

  always #5 ck = ~ck;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    ent_t h;
    int n;
    n = mq.size();
    h = '{instr: '0, id: '0, xreg: '0};
    if (n > 0) h = mq[0];
    chk({tag, ".enable"}, 64'(enable), 64'(n > 0));
    chk({tag, ".instr"},  64'(instruction), 64'(h.instr));
    chk({tag, ".id"},     64'(id), 64'(h.id));
    chk({tag, ".data"},   64'(data_fromXReg), 64'(h.xreg));
    chk({tag, ".count"},  64'(count), 64'(n));
    chk({tag, ".full"},   64'(full), 64'(n == DEP));
    chk({tag, ".empty"},  64'(empty), 64'(n == 0));
  endtask

  // One clock: drive, check in_ready, advance model, check outputs.
  task automatic cyc(string tag, bit v, logic [31:0] ins,
                     logic [XW-1:0] idv, logic [XL-1:0] xd,
                     bit fl, bit fr);
    bit rdy, dopush, dopop;
    ent_t e;
    in_valid = v; in_instruction = ins; in_id = idv;
    in_xreg_data = xd; flush = fl; fpu_ready = fr;
    #1;
    rdy    = (mq.size() < DEP) && !fl;
    dopush = v && rdy;
    dopop  = fr && (mq.size() > 0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    @(posedge ck);
    if (fl) mq.delete();
    else begin
      if (dopop) void'(mq.pop_front());
      if (dopush) begin
        e = '{instr: ins, id: idv, xreg: xd};
        mq.push_back(e);
      end
    end
    #1;
    chk_all(tag);
  endtask

  task automatic idle(string tag, bit fr);
    cyc(tag, 1'b0, '0, '0, '0, 1'b0, fr);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_instruction = '0; in_id = '0;
    in_xreg_data = '0; flush = 0; fpu_ready = 0;
    #1;
    chk_all("reset");
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    @(posedge ck); #2; rst = 1'b0;

    // single push then pop
    cyc("push1", 1, 32'h00A5_0053, 4'd3, 32'h1234_5678, 0, 0);
    idle("pop1", 1);

    // fill and back-pressure
    for (int i = 0; i < 5; i++)
      cyc("fill", 1, 32'h1000 + i, XW'(i), 32'hA000 + i, 0, 0);
    cyc("popfull", 1, 32'h1004, 4'd4, 32'hA004, 0, 1);
    cyc("late4", 1, 32'h1004, 4'd4, 32'hA004, 0, 0);
    for (int i = 0; i < 4; i++) idle("drain", 1);

    // wrap-around streaming
    for (int i = 0; i < 10; i++)
      cyc("wrap", 1, 32'h2000 + i, XW'(i), $urandom, 0, 1);
    idle("wrapend", 1);

    // simultaneous push/pop at count 2
    cyc("pp.a", 1, 32'h3000, 4'd5, 32'h1, 0, 0);
    cyc("pp.b", 1, 32'h3001, 4'd6, 32'h2, 0, 0);
    cyc("pp.c", 1, 32'h3002, 4'd7, 32'h3, 0, 1);
    idle("pp.d", 1);

    // flush at count 3 with valid and fpu_ready raised
    cyc("fl.a", 1, 32'h4000, 4'd8, 32'h4, 0, 0);
    cyc("fl.b", 1, 32'h4001, 4'd9, 32'h5, 0, 0);
    cyc("flush", 1, 32'h4002, 4'd10, 32'h6, 1, 1);
    cyc("postfl", 1, 32'h4003, 4'd11, 32'h7, 0, 0);
    idle("postfl2", 1);

    // asynchronous reset between edges at count 3
    for (int i = 0; i < 3; i++)
      cyc("ar.fill", 1, 32'h5000 + i, XW'(i), 32'h8, 0, 0);
    in_valid = 0; fpu_ready = 0;
    #2; rst = 1'b1; #1;
    mq.delete();
    chk_all("async_rst");
    #2; rst = 1'b0;
    idle("ar.after", 0);
    cyc("ar.push", 1, 32'h5100, 4'd12, 32'h9, 0, 0);
    idle("ar.pop", 1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(0, 3) != 0), $urandom,
          XW'($urandom_range(0, 15)), $urandom,
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
